mem_stage: RTL and testbench

- Memory-access pipeline stage directly downstream of execute. Consumes the execute stage's `alu_op_t` result: effective address, store data and destination register.
- Performs LW/LB/SW/SB over a single-outstanding req/ack data bus. Passes all other ops through to write-back. Stalls upstream while a bus transaction is in flight.
- Detects misaligned word accesses and bus timeouts.

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_lane_align.sv | 40 ++++
 rtl/mem_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage.
//   alu_op_t    - operation code handed over from decode/execute
//   mem_state_t - control states of mem_stage
//   mem_exc_t   - exception codes reported on exc_code
//   is_mem_op / is_store_op / is_byte_op - op classification helpers
package mem_stage_pkg;

  typedef enum logic [3:0] {
    ADD_OP, SUB_OP, AND_OP, OR_OP, XOR_OP, SLT_OP, LUI_OP,
    LW_OP, LB_OP, SW_OP, SB_OP
  } alu_op_t;

  typedef enum logic {IDLE, BUS} mem_state_t;

  typedef enum logic [1:0] {EXC_NONE, EXC_ADEL, EXC_ADES, EXC_BUSERR} mem_exc_t;

  function automatic logic is_mem_op(alu_op_t op);
    return (op == LW_OP) || (op == LB_OP) || (op == SW_OP) || (op == SB_OP);
  endfunction

  function automatic logic is_store_op(alu_op_t op);
    return (op == SW_OP) || (op == SB_OP);
  endfunction

  function automatic logic is_byte_op(alu_op_t op);
    return (op == LB_OP) || (op == SB_OP);
  endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Big-endian lane steering for byte/word accesses (purely combinational).
//   byte_acc - 1 = byte access, 0 = word access
//   offset   - byte offset within the word (addr[1:0])
//   st_data  - register value to store
//   ld_word  - word returned by the bus
//   be       - byte enables, bit 3 = bits 31:24
//   st_lanes - store data placed on the bus lanes
//   ld_data  - load result (word, or selected byte sign-extended)
module mem_lane_align (
  input  logic        byte_acc,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0] ld_byte;

  always_comb begin
    // offset 0 is the most significant lane (big-endian)
    case (offset)
      2'd0:    ld_byte = ld_word[31:24];
      2'd1:    ld_byte = ld_word[23:16];
      2'd2:    ld_byte = ld_word[15:8];
      default: ld_byte = ld_word[7:0];
    endcase

    be       = 4'b1111;
    st_lanes = st_data;
    ld_data  = ld_word;
    if (byte_acc) begin
      be       = 4'b1000 >> offset;
      st_lanes = {4{st_data[7:0]}};
      ld_data  = {{24{ld_byte[7]}}, ld_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Non-memory ops retire in one cycle; LW/LB/SW/SB
// run one req/ack bus transaction at a time, stalling upstream via in_ready.
// Misaligned word accesses and bus timeouts raise a one-cycle exception.
//   in_*      - execute result (valid, op, address, store data, dest reg, we)
//   flush     - discard the incoming or in-flight instruction
//   mem_*     - single-outstanding data bus (registered request side)
//   wb_*      - one-cycle retire to write-back
//   exc_*     - one-cycle exception report
//
// state | meaning
// IDLE  | ready for a new instruction; in_ready high
// BUS   | bus request outstanding, waiting for mem_ack or timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  alu_op_t     in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_wreg,
  input  logic        in_we,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output mem_exc_t    exc_code,
  output logic [31:0] exc_addr
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  mem_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        discard_q, discard_d;
  alu_op_t     op_q, op_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;

  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_valid_q, exc_valid_d;
  mem_exc_t    exc_code_q, exc_code_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic        accept, misalign, start_bus, bus_done, drop;
  logic        la_byte;
  logic [1:0]  la_off;
  logic [3:0]  la_be;
  logic [31:0] la_st, la_ld;

  assign accept    = (state_q == IDLE) && in_valid && !flush;
  assign misalign  = is_mem_op(in_op) && !is_byte_op(in_op) && (in_addr[1:0] != 2'b00);
  assign start_bus = accept && is_mem_op(in_op) && !misalign;
  // ack on the final timeout cycle still counts as a completion
  assign bus_done  = (state_q == BUS) && (mem_ack || cnt_q == CNT_LAST);
  assign drop      = discard_q || flush;

  // request side uses the incoming op; response side uses the latched one
  assign la_byte = (state_q == BUS) ? is_byte_op(op_q) : is_byte_op(in_op);
  assign la_off  = (state_q == BUS) ? addr_q[1:0] : in_addr[1:0];

  mem_lane_align u_lane (
    .byte_acc (la_byte),
    .offset   (la_off),
    .st_data  (in_wdata),
    .ld_word  (mem_rdata),
    .be       (la_be),
    .st_lanes (la_st),
    .ld_data  (la_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      op_q        <= ADD_OP;
      wreg_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= EXC_NONE;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      op_q        <= op_d;
      wreg_q      <= wreg_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: begin
        if (start_bus) begin
          state_d   = BUS;
          cnt_d     = '0;
          discard_d = 1'b0;
        end
      end
      BUS: begin
        cnt_d     = cnt_q + 16'd1;
        discard_d = drop;
        if (bus_done) begin
          state_d   = IDLE;
          cnt_d     = '0;
          discard_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    wreg_d      = wreg_q;
    we_d        = we_q;
    addr_d      = addr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we_q;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_code_d  = exc_code_q;
    exc_addr_d  = exc_addr_q;

    if (accept && !is_mem_op(in_op)) begin
      wb_valid_d = 1'b1;
      wb_we_d    = in_we;
      wb_reg_d   = in_wreg;
      wb_data_d  = in_addr;
    end else if (accept && misalign) begin
      exc_valid_d = 1'b1;
      exc_code_d  = is_store_op(in_op) ? EXC_ADES : EXC_ADEL;
      exc_addr_d  = in_addr;
    end else if (start_bus) begin
      mem_req_d   = 1'b1;
      mem_we_d    = is_store_op(in_op);
      mem_addr_d  = {in_addr[31:2], 2'b00};
      mem_be_d    = la_be;
      mem_wdata_d = la_st;
      op_d        = in_op;
      wreg_d      = in_wreg;
      we_d        = in_we;
      addr_d      = in_addr;
    end else if (bus_done) begin
      mem_req_d = 1'b0;
      if (mem_ack) begin
        wb_valid_d = !drop;
        wb_reg_d   = wreg_q;
        wb_we_d    = is_store_op(op_q) ? 1'b0 : we_q;
        wb_data_d  = is_store_op(op_q) ? 32'd0 : la_ld;
      end else begin
        exc_valid_d = !drop;
        exc_code_d  = EXC_BUSERR;
        exc_addr_d  = addr_q;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of directed transactions,
// randomized transactions scored against a behavioural model, and
// hand-written sequences for flush and asynchronous reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_we, flush;
  alu_op_t     in_op;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_wreg;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, wb_we, exc_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, exc_addr;
  mem_exc_t    exc_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_wreg(in_wreg),
    .in_we(in_we), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr)
  );

  typedef struct {
    logic        bus;
    logic        store;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        exc;
    mem_exc_t    code;
    logic        wb_we;
    logic [31:0] val;     // wb_data, or exc_addr on an exception
  } exp_t;

  typedef struct {
    alu_op_t     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic        we;
    int          delay;   // wait cycles before ack; >= TO means never ack
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: expected result of one isolated transaction.
  function automatic exp_t model(alu_op_t op, logic [31:0] addr, logic [31:0] wdata,
                                 logic we, int delay, logic [31:0] rdata);
    exp_t e;
    logic       word, mem, st;
    int         off;
    logic [7:0] b;
    mem  = op inside {LW_OP, LB_OP, SW_OP, SB_OP};
    word = op inside {LW_OP, SW_OP};
    st   = op inside {SW_OP, SB_OP};
    off  = int'(addr[1:0]);
    e = '{bus: 1'b0, store: st, be: 4'h0, mwdata: 32'h0, exc: 1'b0,
          code: EXC_NONE, wb_we: we, val: addr};
    if (!mem) return e;
    if (word && off != 0) begin
      e.exc  = 1'b1;
      e.code = st ? EXC_ADES : EXC_ADEL;
      return e;
    end
    e.bus    = 1'b1;
    e.be     = word ? 4'hF : 4'(8 >> off);
    e.mwdata = word ? wdata : {4{wdata[7:0]}};
    if (delay >= TO) begin
      e.exc  = 1'b1;
      e.code = EXC_BUSERR;
    end else if (st) begin
      e.wb_we = 1'b0;
      e.val   = 32'h0;
    end else if (word) begin
      e.val = rdata;
    end else begin
      b     = 8'((rdata >> (8 * (3 - off))) & 32'hFF);
      e.val = 32'($signed(b));
    end
    return e;
  endfunction

  task automatic do_txn(input alu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wreg, input logic we, input int delay,
                        input logic [31:0] rdata, input exp_t e);
    int cyc;
    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
    in_wreg = wreg; in_we = we;
    @(negedge clk);
    in_valid = 1'b0; in_op = ADD_OP; in_addr = $urandom; in_wdata = $urandom;
    chk("mem_req_start", mem_req, e.bus);
    if (e.bus) begin
      cyc = 0;
      while (mem_req && cyc < 20) begin
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("mem_be", mem_be, e.be);
        chk("mem_we", mem_we, e.store);
        if (e.store) chk("mem_wdata", mem_wdata, e.mwdata);
        chk("ready_busy", in_ready, 0);
        if (cyc == delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        cyc++;
      end
      chk("req_cycles", cyc, (delay < TO) ? delay + 1 : TO);
    end
    if (e.exc) begin
      chk("exc_valid", exc_valid, 1);
      chk("exc_code", 32'(exc_code), 32'(e.code));
      chk("exc_addr", exc_addr, e.val);
      chk("wb_quiet", wb_valid, 0);
    end else begin
      chk("wb_valid", wb_valid, 1);
      chk("wb_we", wb_we, e.wb_we);
      if (e.wb_we) chk("wb_reg", wb_reg, wreg);
      chk("wb_data", wb_data, e.val);
      chk("exc_quiet", exc_valid, 0);
    end
    chk("ready_after", in_ready, 1);
    chk("req_after", mem_req, 0);
    @(negedge clk);
    chk("wb_pulse", wb_valid, 0);
    chk("exc_pulse", exc_valid, 0);
  endtask

  // Start a LW to 0x80 and leave the stage in its first BUS cycle.
  task automatic start_lw80();
    @(negedge clk);
    in_valid = 1'b1; in_op = LW_OP; in_addr = 32'h80; in_wreg = 5'd9; in_we = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("seq_req", mem_req, 1);
  endtask

  vec_t tbl[10];
  alu_op_t ops[11] = '{ADD_OP, SUB_OP, AND_OP, OR_OP, XOR_OP, SLT_OP, LUI_OP,
                       LW_OP, LB_OP, SW_OP, SB_OP};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = ADD_OP; in_addr = '0; in_wdata = '0;
    in_wreg = '0; in_we = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

    tbl[0] = '{ADD_OP, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 0, 32'h0,
               '{1'b0, 1'b0, 4'h0, 32'h0, 1'b0, EXC_NONE, 1'b1, 32'h1234_5678}};
    tbl[1] = '{LB_OP, 32'h0000_1003, 32'h0, 5'd5, 1'b1, 2, 32'h1122_3380,
               '{1'b1, 1'b0, 4'b0001, 32'h0, 1'b0, EXC_NONE, 1'b1, 32'hFFFF_FF80}};
    tbl[2] = '{SB_OP, 32'h21, 32'hAB, 5'd7, 1'b0, 0, 32'h0,
               '{1'b1, 1'b1, 4'b0100, 32'hABAB_ABAB, 1'b0, EXC_NONE, 1'b0, 32'h0}};
    tbl[3] = '{LW_OP, 32'h102, 32'h0, 5'd4, 1'b1, 0, 32'h0,
               '{1'b0, 1'b0, 4'h0, 32'h0, 1'b1, EXC_ADEL, 1'b0, 32'h102}};
    tbl[4] = '{SW_OP, 32'h102, 32'h55, 5'd0, 1'b0, 0, 32'h0,
               '{1'b0, 1'b1, 4'h0, 32'h0, 1'b1, EXC_ADES, 1'b0, 32'h102}};
    tbl[5] = '{LW_OP, 32'h40, 32'h0, 5'd6, 1'b1, 99, 32'h0,
               '{1'b1, 1'b0, 4'hF, 32'h0, 1'b1, EXC_BUSERR, 1'b0, 32'h40}};
    tbl[6] = '{LW_OP, 32'h40, 32'h0, 5'd6, 1'b1, 3, 32'hDEAD_BEEF,
               '{1'b1, 1'b0, 4'hF, 32'h0, 1'b0, EXC_NONE, 1'b1, 32'hDEAD_BEEF}};
    tbl[7] = '{SUB_OP, 32'h0BAD_F00D, 32'h0, 5'd8, 1'b0, 0, 32'h0,
               '{1'b0, 1'b0, 4'h0, 32'h0, 1'b0, EXC_NONE, 1'b0, 32'h0BAD_F00D}};
    tbl[8] = '{LB_OP, 32'h2000, 32'h0, 5'd2, 1'b1, 1, 32'h7F00_00FF,
               '{1'b1, 1'b0, 4'b1000, 32'h0, 1'b0, EXC_NONE, 1'b1, 32'h0000_007F}};
    tbl[9] = '{SW_OP, 32'h44, 32'hCAFE_F00D, 5'd1, 1'b1, 1, 32'h0,
               '{1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, EXC_NONE, 1'b0, 32'h0}};

    #3;
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_exc", exc_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      do_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].wreg, tbl[i].we,
             tbl[i].delay, tbl[i].rdata, tbl[i].e);

    for (int i = 0; i < 40; i++) begin
      alu_op_t     op;
      logic [31:0] a, wd, rd;
      logic [4:0]  wr;
      logic        we;
      int          dly;
      op  = ops[$urandom_range(0, 10)];
      a   = $urandom;
      wd  = $urandom;
      rd  = $urandom;
      wr  = 5'($urandom);
      we  = 1'($urandom);
      dly = $urandom_range(0, TO + 1);
      // bias word accesses toward aligned addresses so the bus path is exercised
      if ((op == LW_OP || op == SW_OP) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_txn(op, a, wd, wr, we, dly, rd, model(op, a, wd, we, dly, rd));
    end

    // flush during BUS, ack one cycle later: retire is suppressed
    start_lw80();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("flush_bus_wb", wb_valid, 0);
    chk("flush_bus_req", mem_req, 0);
    chk("flush_bus_ready", in_ready, 1);
    @(negedge clk);
    chk("flush_bus_wb2", wb_valid, 0);

    // flush coincident with ack
    start_lw80();
    flush = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    flush = 1'b0; mem_ack = 1'b0;
    chk("flush_ack_wb", wb_valid, 0);
    chk("flush_ack_ready", in_ready, 1);

    // flush during BUS then timeout: exception is suppressed
    start_lw80();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (TO - 1) @(negedge clk);
    chk("flush_to_exc", exc_valid, 0);
    chk("flush_to_req", mem_req, 0);

    // flush in IDLE discards the incoming instruction
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = LW_OP; in_addr = 32'h100;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_req", mem_req, 0);
    chk("flush_idle_wb", wb_valid, 0);
    chk("flush_idle_ready", in_ready, 1);

    // stray ack in IDLE is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_wb", wb_valid, 0);
    chk("idle_ack_ready", in_ready, 1);

    // asynchronous reset in the middle of a bus transaction
    start_lw80();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready_after", in_ready, 1);
    chk("arst_wb", wb_valid, 0);
    do_txn(ADD_OP, 32'h77, 32'h0, 5'd1, 1'b1, 0, 32'h0,
           model(ADD_OP, 32'h77, 32'h0, 1'b1, 0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
